// File: rtl/axi_dma_desc_split.sv
// Descriptor segmenter: cuts descriptors at MAX_SEG_LEN and BOUNDARY crossings and merges per-segment status.
// Optional feature macro: AXI_DMA_DESC_SPLIT_MERGE_EN (status merge; undefined = per-segment status forwarding).
module axi_dma_desc_split #(
   parameter int AXI_ADDR_WIDTH = 16,
   parameter int LEN_WIDTH      = 20,
   parameter int TAG_WIDTH      = 8,
   parameter int USER_WIDTH     = 1,
   parameter int MAX_SEG_LEN    = 256,
   parameter int BOUNDARY       = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axis_desc_addr,
   input  logic [LEN_WIDTH-1:0]      s_axis_desc_len,
   input  logic [TAG_WIDTH-1:0]      s_axis_desc_tag,
   input  logic [USER_WIDTH-1:0]     s_axis_desc_user,
   input  logic                      s_axis_desc_valid,
   output logic                      s_axis_desc_ready,
   output logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_addr,
   output logic [LEN_WIDTH-1:0]      m_axis_desc_len,
   output logic [TAG_WIDTH:0]        m_axis_desc_tag,
   output logic [USER_WIDTH-1:0]     m_axis_desc_user,
   output logic                      m_axis_desc_valid,
   input  logic                      m_axis_desc_ready,
   input  logic [LEN_WIDTH-1:0]      s_axis_desc_status_len,
   input  logic [TAG_WIDTH:0]        s_axis_desc_status_tag,
   input  logic [USER_WIDTH-1:0]     s_axis_desc_status_user,
   input  logic                      s_axis_desc_status_valid,
   output logic [LEN_WIDTH-1:0]      m_axis_desc_status_len,
   output logic [TAG_WIDTH-1:0]      m_axis_desc_status_tag,
   output logic [USER_WIDTH-1:0]     m_axis_desc_status_user,
   output logic                      m_axis_desc_status_valid
);
   localparam int SW = LEN_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

   state_t                    state_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, m_addr_q;
   logic [LEN_WIDTH-1:0]      rem_q, m_len_q;
   logic [TAG_WIDTH-1:0]      tag_q;
   logic [TAG_WIDTH:0]        m_tag_q;
   logic [USER_WIDTH-1:0]     user_q, m_user_q;
   logic                      m_valid_q;
   logic [SW-1:0]             room_d, seg_d;
   logic                      last_d;

   // Ready is forced low while reset is held so nothing is accepted during reset.
   assign s_axis_desc_ready = (state_q == IDLE) && !rst;
   assign m_axis_desc_addr  = m_addr_q;
   assign m_axis_desc_len   = m_len_q;
   assign m_axis_desc_tag   = m_tag_q;
   assign m_axis_desc_user  = m_user_q;
   assign m_axis_desc_valid = m_valid_q;

   // Segment length is the tightest of: bytes left, max segment, bytes to next boundary.
   always_comb begin
      room_d = SW'(BOUNDARY) - SW'(addr_q & AXI_ADDR_WIDTH'(BOUNDARY - 1));
      seg_d  = {1'b0, rem_q};
      if (SW'(MAX_SEG_LEN) < seg_d) seg_d = SW'(MAX_SEG_LEN);
      if (room_d < seg_d) seg_d = room_d;
      last_d = (seg_d == {1'b0, rem_q});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         tag_q     <= '0;
         user_q    <= '0;
         m_addr_q  <= '0;
         m_len_q   <= '0;
         m_tag_q   <= '0;
         m_user_q  <= '0;
         m_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (s_axis_desc_valid) begin
               addr_q  <= s_axis_desc_addr;
               rem_q   <= s_axis_desc_len;
               tag_q   <= s_axis_desc_tag;
               user_q  <= s_axis_desc_user;
               state_q <= CALC;
            end
            CALC: begin
               m_addr_q  <= addr_q;
               m_len_q   <= seg_d[LEN_WIDTH-1:0];
               m_tag_q   <= {last_d, tag_q};
               m_user_q  <= user_q;
               m_valid_q <= 1'b1;
               state_q   <= ISSUE;
            end
            ISSUE: if (m_axis_desc_ready) begin
               addr_q    <= addr_q + AXI_ADDR_WIDTH'(m_len_q);
               rem_q     <= rem_q - m_len_q;
               m_valid_q <= 1'b0;
               state_q   <= m_tag_q[TAG_WIDTH] ? IDLE : CALC;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic [LEN_WIDTH-1:0]  st_len_q;
   logic [TAG_WIDTH-1:0]  st_tag_q;
   logic [USER_WIDTH-1:0] st_user_q;
   logic                  st_valid_q;

   assign m_axis_desc_status_len   = st_len_q;
   assign m_axis_desc_status_tag   = st_tag_q;
   assign m_axis_desc_status_user  = st_user_q;
   assign m_axis_desc_status_valid = st_valid_q;

`ifdef AXI_DMA_DESC_SPLIT_MERGE_EN
   logic [LEN_WIDTH-1:0] acc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= '0;
         st_len_q   <= '0;
         st_tag_q   <= '0;
         st_user_q  <= '0;
         st_valid_q <= 1'b0;
      end else begin
         st_valid_q <= 1'b0;
         if (s_axis_desc_status_valid) begin
            if (s_axis_desc_status_tag[TAG_WIDTH]) begin
               st_len_q   <= acc_q + s_axis_desc_status_len;
               st_tag_q   <= s_axis_desc_status_tag[TAG_WIDTH-1:0];
               st_user_q  <= s_axis_desc_status_user;
               st_valid_q <= 1'b1;
               acc_q      <= '0;
            end else begin
               acc_q <= acc_q + s_axis_desc_status_len;
            end
         end
      end
   end
`else
   logic status_last_unused;
   assign status_last_unused = s_axis_desc_status_tag[TAG_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_len_q   <= '0;
         st_tag_q   <= '0;
         st_user_q  <= '0;
         st_valid_q <= 1'b0;
      end else begin
         st_valid_q <= s_axis_desc_status_valid;
         if (s_axis_desc_status_valid) begin
            st_len_q  <= s_axis_desc_status_len;
            st_tag_q  <= s_axis_desc_status_tag[TAG_WIDTH-1:0];
            st_user_q <= s_axis_desc_status_user;
         end
      end
   end
`endif

endmodule

// File: tb/tb_axi_dma_desc_split.sv
// Directed bench for axi_dma_desc_split: segment table, back-pressure, status merge/forward, reset mid-descriptor.
module tb_axi_dma_desc_split;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] s_addr = '0;
   logic [19:0] s_len = '0;
   logic [7:0]  s_tag = '0;
   logic [0:0]  s_user = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] m_addr;
   logic [19:0] m_len;
   logic [8:0]  m_tag;
   logic [0:0]  m_user;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [19:0] st_len = '0;
   logic [8:0]  st_tag = '0;
   logic [0:0]  st_user = '0;
   logic        st_valid = 1'b0;
   logic [19:0] ms_len;
   logic [7:0]  ms_tag;
   logic [0:0]  ms_user;
   logic        ms_valid;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_dma_desc_split dut (
      .clk(clk), .rst(rst),
      .s_axis_desc_addr(s_addr), .s_axis_desc_len(s_len), .s_axis_desc_tag(s_tag),
      .s_axis_desc_user(s_user), .s_axis_desc_valid(s_valid), .s_axis_desc_ready(s_ready),
      .m_axis_desc_addr(m_addr), .m_axis_desc_len(m_len), .m_axis_desc_tag(m_tag),
      .m_axis_desc_user(m_user), .m_axis_desc_valid(m_valid), .m_axis_desc_ready(m_ready),
      .s_axis_desc_status_len(st_len), .s_axis_desc_status_tag(st_tag),
      .s_axis_desc_status_user(st_user), .s_axis_desc_status_valid(st_valid),
      .m_axis_desc_status_len(ms_len), .m_axis_desc_status_tag(ms_tag),
      .m_axis_desc_status_user(ms_user), .m_axis_desc_status_valid(ms_valid)
   );

   typedef struct {
      logic [15:0]       addr;
      logic [19:0]       len;
      logic [7:0]        tag;
      int                nseg;
      logic [2:0][15:0]  ea;
      logic [2:0][19:0]  el;
   } vec_t;

   vec_t vt[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for DUT", nm);
   endtask

   task automatic send_desc(input logic [15:0] a, input logic [19:0] l, input logic [7:0] t);
      bit hs = 0;
      s_addr = a; s_len = l; s_tag = t; s_user = 1'b1; s_valid = 1'b1;
      for (int n = 0; n < 30 && !hs; n++) begin
         @(negedge clk);
         hs = s_ready;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      if (!hs) timeout("desc_accept");
   endtask

   task automatic get_seg(output logic [15:0] a, output logic [19:0] l, output logic [8:0] t,
                          output logic u);
      bit ok = 0;
      a = '0; l = '0; t = '0; u = 1'b0;
      for (int n = 0; n < 30 && !ok; n++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            a = m_addr; l = m_len; t = m_tag; u = m_user[0];
            ok = 1;
            @(posedge clk);
            #1;
         end
      end
      if (!ok) timeout("seg_wait");
   endtask

   task automatic send_status(input logic [19:0] l, input logic [8:0] t);
      st_len = l; st_tag = t; st_user = 1'b1; st_valid = 1'b1;
      @(posedge clk);
      #1;
      st_valid = 1'b0;
   endtask

   initial begin
      logic [15:0] a;
      logic [19:0] l;
      logic [8:0]  t;
      logic        u;
      logic [8:0]  et;

      vt[0] = '{16'h0000, 20'h250, 8'h5A, 3, {16'h0200, 16'h0100, 16'h0000}, {20'h050, 20'h100, 20'h100}};
      vt[1] = '{16'h0FF0, 20'h030, 8'h11, 2, {16'h0000, 16'h1000, 16'h0FF0}, {20'h000, 20'h020, 20'h010}};
      vt[2] = '{16'h1234, 20'h000, 8'h22, 1, {16'h0000, 16'h0000, 16'h1234}, {20'h000, 20'h000, 20'h000}};
      vt[3] = '{16'h0F80, 20'h200, 8'h33, 3, {16'h1100, 16'h1000, 16'h0F80}, {20'h080, 20'h100, 20'h080}};
      vt[4] = '{16'hFFF0, 20'h020, 8'h44, 2, {16'h0000, 16'h0000, 16'hFFF0}, {20'h000, 20'h010, 20'h010}};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_addr_len", {m_addr, m_len[15:0]}, 0);
      chk("rst_ms_valid", ms_valid, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", s_ready, 1);

      // table-driven segmentation
      for (int v = 0; v < 5; v++) begin
         send_desc(vt[v].addr, vt[v].len, vt[v].tag);
         chk("lat_calc_no_valid", m_valid, 0);
         for (int s = 0; s < vt[v].nseg; s++) begin
            get_seg(a, l, t, u);
            et = {(s == vt[v].nseg - 1), vt[v].tag};
            chk($sformatf("v%0d_s%0d_addr", v, s), a, vt[v].ea[s]);
            chk($sformatf("v%0d_s%0d_len", v, s), l, vt[v].el[s]);
            chk($sformatf("v%0d_s%0d_tag", v, s), t, et);
            chk($sformatf("v%0d_s%0d_user", v, s), u, 1);
         end
         chk($sformatf("v%0d_no_extra", v), m_valid, 0);
         chk($sformatf("v%0d_idle_ready", v), s_ready, 1);
      end

      // back-pressure on segment 2
      send_desc(16'h0000, 20'h250, 8'h5A);
      get_seg(a, l, t, u);
      chk("bp_s1_addr", a, 16'h0000);
      m_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("bp_s2_valid", m_valid, 1);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold%0d", c), {m_valid, m_tag, m_addr, m_len[15:0]},
             {1'b1, 9'h05A, 16'h0100, 16'h0100});
         chk($sformatf("bp_sready%0d", c), s_ready, 0);
      end
      m_ready = 1'b1;
      get_seg(a, l, t, u);
      chk("bp_s2", {t, a, l[15:0]}, {9'h05A, 16'h0100, 16'h0100});
      get_seg(a, l, t, u);
      chk("bp_s3", {t, a, l[15:0]}, {9'h15A, 16'h0200, 16'h0050});
      chk("bp_no_extra", m_valid, 0);

      // status path
      send_status(20'h100, 9'h05A);
`ifdef AXI_DMA_DESC_SPLIT_MERGE_EN
      chk("mrg_st1_quiet", ms_valid, 0);
      send_status(20'h100, 9'h05A);
      chk("mrg_st2_quiet", ms_valid, 0);
      send_status(20'h050, 9'h15A);
      chk("mrg_out", {ms_valid, ms_tag, ms_len}, {1'b1, 8'h5A, 20'h250});
`else
      chk("fwd_st1", {ms_valid, ms_tag, ms_len}, {1'b1, 8'h5A, 20'h100});
      send_status(20'h100, 9'h05A);
      chk("fwd_st2", {ms_valid, ms_tag, ms_len}, {1'b1, 8'h5A, 20'h100});
      send_status(20'h050, 9'h15A);
      chk("fwd_st3", {ms_valid, ms_tag, ms_len}, {1'b1, 8'h5A, 20'h050});
`endif
      @(posedge clk);
      #1;
      chk("st_pulse_1cyc", ms_valid, 0);

      // back-to-back last statuses, then a zero-length one
      st_len = 20'h10; st_tag = 9'h101; st_user = 1'b0; st_valid = 1'b1;
      @(posedge clk);
      #1;
      st_len = 20'h20; st_tag = 9'h102;
      chk("b2b_first", {ms_valid, ms_tag, ms_len, ms_user}, {1'b1, 8'h01, 20'h10, 1'b0});
      @(posedge clk);
      #1;
      st_valid = 1'b0;
      chk("b2b_second", {ms_valid, ms_tag, ms_len}, {1'b1, 8'h02, 20'h20});
      send_status(20'h0, 9'h122);
      chk("zero_len_status", {ms_valid, ms_tag, ms_len, ms_user}, {1'b1, 8'h22, 20'h0, 1'b1});

      // reset mid-segment 2 with a partial merge pending
      send_desc(16'h0000, 20'h250, 8'h5A);
      get_seg(a, l, t, u);
      m_ready = 1'b0;
      send_status(20'h040, 9'h05A);
      chk("pre_rst_s2_valid", m_valid, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", {m_valid, m_addr, m_len, m_tag}, 0);
      chk("mid_rst_status", {ms_valid, ms_len, ms_tag}, 0);
      chk("mid_rst_ready", s_ready, 0);
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rel_ready", s_ready, 1);
      chk("rel_no_valid", m_valid, 0);
      send_desc(16'h0300, 20'h080, 8'h77);
      get_seg(a, l, t, u);
      chk("rst_new_seg", {t, a, l[15:0]}, {9'h177, 16'h0300, 16'h0080});
      chk("rst_new_single", m_valid, 0);
      send_status(20'h080, 9'h177);
      chk("rst_acc_restart", {ms_valid, ms_tag, ms_len}, {1'b1, 8'h77, 20'h080});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axi_dma_desc_split.md
# axi_dma_desc_split

Descriptor segmenter between the descriptor mux output and the AXI DMA core. Splits each incoming descriptor into segments no longer than MAX_SEG_LEN that never cross a BOUNDARY-aligned address boundary. Merges the per-segment status returned by the core back into one status per original descriptor. The core completes segments in issue order.

## Interface
- AXI_ADDR_WIDTH, 16, byte address width
- LEN_WIDTH, 20, length field width, bytes
- TAG_WIDTH, 8, input tag width; core-side tag is TAG_WIDTH+1, with the MSB as the last-segment flag
- USER_WIDTH, 1, descriptor/status user width
- MAX_SEG_LEN, 256, maximum segment length in bytes; power of two, ≤ BOUNDARY, < 2^LEN_WIDTH
- BOUNDARY, 4096, no-cross address boundary; power of two
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_axis_desc_addr/len/tag/user  in  AXI_ADDR_WIDTH/LEN_WIDTH/TAG_WIDTH/USER_WIDTH  incoming descriptor
- s_axis_desc_valid  in  1; s_axis_desc_ready  out  1
- m_axis_desc_addr/len/user  out  AXI_ADDR_WIDTH/LEN_WIDTH/USER_WIDTH  segment to core
- m_axis_desc_tag  out  TAG_WIDTH+1  {last, tag}
- m_axis_desc_valid  out  1; m_axis_desc_ready  in  1
- s_axis_desc_status_len/tag/user/valid  in  LEN_WIDTH/TAG_WIDTH+1/USER_WIDTH/1  segment status from core; no ready
- m_axis_desc_status_len/tag/user/valid  out  LEN_WIDTH/TAG_WIDTH/USER_WIDTH/1  merged status; no ready

## Operation
- FSM states: IDLE, CALC, ISSUE.
- IDLE: s_axis_desc_ready=1. A handshake latches addr, remaining=len, tag and user, then goes to CALC.
- CALC: computes seg = min(remaining, MAX_SEG_LEN, BOUNDARY − (addr & (BOUNDARY−1))), evaluated at LEN_WIDTH+1 bits. Loads the m_axis_desc_* registers, with last = (seg == remaining). Sets m_axis_desc_valid and goes to ISSUE.
- ISSUE: holds all outputs stable until m_axis_desc_ready.
  - On handshake: addr += seg (wraps mod 2^AXI_ADDR_WIDTH), remaining −= seg, valid drops.
  - Next state is IDLE if last, otherwise CALC.
- len==0: one segment is issued with len 0, last=1, at the unmodified addr.
- Status path, on s_axis_desc_status_valid:
  - last flag clear: acc += status len (wraps mod 2^LEN_WIDTH). No output.
  - last flag set: m_axis_desc_status_len = acc + status len, tag = status tag[TAG_WIDTH−1:0], user = status user, valid pulses for 1 cycle; acc is cleared to 0.
- The status path is independent of the FSM. Status events and descriptor handshakes in the same cycle are both processed.

## Timing
- Reset values: s_axis_desc_ready=0 while rst is high, and 1 on the first cycle after release (IDLE). All m_axis_desc_* = 0, all m_axis_desc_status_* = 0, acc=0, state IDLE.
- Input handshake at edge N → first segment valid after edge N+1.
- Segment handshake at edge K → next segment valid after edge K+1. Peak rate is 1 segment per 2 cycles.
- Next input descriptor is accepted no earlier than the cycle after the last segment's handshake.
- Status latency: core status at edge N → merged status valid in cycle N+1, for exactly 1 cycle. Back-to-back last statuses give back-to-back output pulses.
- m_axis_desc_* must not change while valid=1 && ready=0.
- rst asserted mid-descriptor or mid-merge: immediate return to the reset values; partial segments and acc are discarded.

## Configuration
- AXI_DMA_DESC_SPLIT_MERGE_EN
  - Defined: status merging as described above.
  - Undefined: acc logic is removed. Every core status is forwarded 1 cycle later with its own segment len, tag = lower TAG_WIDTH bits, and the last flag dropped. Segmentation is unchanged.

## Test plan
- addr 0x0000, len 0x250, tag 0x5A, ready=1 → segments (0x0000,0x100,tag 0x05A), (0x0100,0x100,0x05A), (0x0200,0x050,0x15A).
- addr 0x0FF0, len 0x30 → (0x0FF0,0x010,last 0), (0x1000,0x020,last 1); no segment crosses 0x1000.
- m_axis_desc_ready held low 5 cycles during segment 2 → outputs stable throughout, s_axis_desc_ready=0, no segment lost or duplicated.
- Merge enabled: statuses 0x100/0x05A, 0x100/0x05A, 0x050/0x15A → single m status len 0x250, tag 0x5A, one-cycle pulse. Macro undefined: three pulses, lengths 0x100, 0x100, 0x050.
- len 0 at addr 0x1234 → one segment (0x1234, 0, last 1); its status yields merged len 0.
- rst pulsed mid-segment 2 of a 0x250 descriptor → all outputs 0 immediately. After release: ready=1, and a new 0x80 descriptor issues as one segment; acc restarts at 0.
